// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO pointer helpers: gray/binary conversion and synchronizer depth limits.
// Pure declarations; no timing or flow-control behaviour of its own.
package async_fifo_pkg;

  localparam int PTR_W           = 4;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary decoder, mirror of binary_to_gray.
// Zero latency; no flow control.
module gray_to_binary #(
  parameter int BITSIZE = 4
) (
  input  logic [BITSIZE-1:0] gray,
  output logic [BITSIZE-1:0] bin
);

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < BITSIZE; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_ptr_sync_decoder.sv
// Synchronizes a foreign-domain gray pointer, decodes it and reports advances and illegal steps.
// bin_out lags a stable gray_in by SYNC_STAGES+1 edges; no backpressure, outputs are informational.
module gray_ptr_sync_decoder
  import async_fifo_pkg::*;
#(
  parameter int BITSIZE     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITSIZE-1:0] gray_in,
  input  logic               err_clr,
  output logic [BITSIZE-1:0] gray_sync,
  output logic [BITSIZE-1:0] bin_out,
  output logic               ptr_update,
  output logic [BITSIZE-1:0] ptr_delta,
  output logic               multi_bit_err
);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $fatal(1, "gray_ptr_sync_decoder: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  (* ASYNC_REG = "TRUE" *) logic [BITSIZE-1:0] sync_q [SYNC_STAGES];

  logic [BITSIZE-1:0] gray_prev;
  logic [BITSIZE-1:0] bin_new;
  logic [BITSIZE-1:0] gray_diff;
  logic [BITSIZE-1:0] delta_nxt;
  logic               changed;
  logic               multi_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  gray_to_binary #(
    .BITSIZE (BITSIZE)
  ) u_gray_to_binary (
    .gray (gray_sync),
    .bin  (bin_new)
  );

  // More than one bit set: clearing the lowest set bit still leaves a non-zero value.
  assign gray_diff  = gray_sync ^ gray_prev;
  assign changed    = |gray_diff;
  assign multi_step = changed && |(gray_diff & (gray_diff - BITSIZE'(1)));
  assign delta_nxt  = bin_new - bin_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev     <= '0;
      bin_out       <= '0;
      ptr_update    <= 1'b0;
      ptr_delta     <= '0;
      multi_bit_err <= 1'b0;
    end else begin
      gray_prev  <= gray_sync;
      bin_out    <= bin_new;
      ptr_update <= changed;
      ptr_delta  <= changed ? delta_nxt : '0;
      // A fresh illegal step outranks a simultaneous clear.
      if (multi_step) begin
        multi_bit_err <= 1'b1;
      end else if (err_clr) begin
        multi_bit_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// Directed self-checking bench for gray_ptr_sync_decoder (BITSIZE=4, SYNC_STAGES=2).
module tb_gray_ptr_sync_decoder;
  import async_fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] gray_sync;
  logic [3:0] bin_out;
  logic       ptr_update;
  logic [3:0] ptr_delta;
  logic       multi_bit_err;

  int errors;
  int checks;

  gray_ptr_sync_decoder #(
    .BITSIZE     (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gray_in       (gray_in),
    .err_clr       (err_clr),
    .gray_sync     (gray_sync),
    .bin_out       (bin_out),
    .ptr_update    (ptr_update),
    .ptr_delta     (ptr_delta),
    .multi_bit_err (multi_bit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 2 time units so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    gray_in = 4'b1010;
    err_clr = 1'b0;
    repeat (3) step();
    checks++; if (gray_sync !== 4'd0) begin errors++; $display("FAIL reset_gray_sync got=%0d exp=0", gray_sync); end
    checks++; if (bin_out !== 4'd0) begin errors++; $display("FAIL reset_bin_out got=%0d exp=0", bin_out); end
    checks++; if (ptr_update !== 1'b0) begin errors++; $display("FAIL reset_ptr_update got=%0b exp=0", ptr_update); end
    checks++; if (ptr_delta !== 4'd0) begin errors++; $display("FAIL reset_ptr_delta got=%0d exp=0", ptr_delta); end
    checks++; if (multi_bit_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", multi_bit_err); end
    rst_n = 1'b1;
    step();
    step();
    checks++; if (gray_sync !== 4'b1010) begin errors++; $display("FAIL rel_gray_sync_e2 got=%b exp=1010", gray_sync); end
    checks++; if (bin_out !== 4'd0 || ptr_update !== 1'b0) begin
      errors++; $display("FAIL rel_early_e2 bin=%0d upd=%0b exp bin=0 upd=0", bin_out, ptr_update);
    end
    step();
    checks++; if (bin_out !== 4'd12) begin errors++; $display("FAIL rel_bin_out_e3 got=%0d exp=12", bin_out); end
    checks++; if (ptr_update !== 1'b1) begin errors++; $display("FAIL rel_ptr_update_e3 got=%0b exp=1", ptr_update); end
    checks++; if (ptr_delta !== 4'd12) begin errors++; $display("FAIL rel_ptr_delta_e3 got=%0d exp=12", ptr_delta); end
    checks++; if (multi_bit_err !== 1'b1) begin errors++; $display("FAIL rel_err_e3 got=%0b exp=1", multi_bit_err); end
    step();
    checks++; if (ptr_update !== 1'b0 || ptr_delta !== 4'd0 || bin_out !== 4'd12) begin
      errors++; $display("FAIL rel_hold_e4 upd=%0b delta=%0d bin=%0d exp 0/0/12", ptr_update, ptr_delta, bin_out);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (multi_bit_err !== 1'b0) begin errors++; $display("FAIL rel_err_clr got=%0b exp=0", multi_bit_err); end
  endtask

  task automatic test_count();
    logic [3:0] exp_bin;
    logic [3:0] prev_bin;
    int         upd_cnt;
    rst_n   = 1'b0;
    gray_in = 4'd0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (bin_out !== 4'd0 || ptr_update !== 1'b0) begin
      errors++; $display("FAIL count_start bin=%0d upd=%0b exp 0/0", bin_out, ptr_update);
    end
    for (int v = 1; v <= 16; v++) begin
      exp_bin  = 4'(v);
      prev_bin = 4'(v - 1);
      gray_in  = bin2gray(exp_bin);
      upd_cnt  = 0;
      for (int k = 1; k <= 4; k++) begin
        step();
        if (ptr_update === 1'b1) upd_cnt++;
        if (k == 2) begin
          checks++; if (bin_out !== prev_bin) begin errors++; $display("FAIL count_latency v=%0d got=%0d exp=%0d", v, bin_out, prev_bin); end
        end
        if (k == 3) begin
          checks++; if (bin_out !== exp_bin) begin errors++; $display("FAIL count_bin v=%0d got=%0d exp=%0d", v, bin_out, exp_bin); end
          checks++; if (ptr_delta !== 4'd1) begin errors++; $display("FAIL count_delta v=%0d got=%0d exp=1", v, ptr_delta); end
        end
      end
      checks++; if (upd_cnt != 1) begin errors++; $display("FAIL count_pulses v=%0d got=%0d exp=1", v, upd_cnt); end
    end
    checks++; if (multi_bit_err !== 1'b0) begin errors++; $display("FAIL count_err got=%0b exp=0", multi_bit_err); end
  endtask

  task automatic test_multi_step();
    gray_in = 4'b0001;
    repeat (4) step();
    checks++; if (bin_out !== 4'd1 || multi_bit_err !== 1'b0) begin
      errors++; $display("FAIL multi_setup bin=%0d err=%0b exp 1/0", bin_out, multi_bit_err);
    end
    gray_in = 4'b0110;
    repeat (3) step();
    checks++; if (ptr_update !== 1'b1) begin errors++; $display("FAIL multi_update got=%0b exp=1", ptr_update); end
    checks++; if (ptr_delta !== 4'd3) begin errors++; $display("FAIL multi_delta got=%0d exp=3", ptr_delta); end
    checks++; if (bin_out !== 4'd4) begin errors++; $display("FAIL multi_bin got=%0d exp=4", bin_out); end
    checks++; if (multi_bit_err !== 1'b1) begin errors++; $display("FAIL multi_err got=%0b exp=1", multi_bit_err); end
    step();
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (multi_bit_err !== 1'b0) begin errors++; $display("FAIL errclr_clear got=%0b exp=0", multi_bit_err); end
    // 0110 -> 0000 is itself illegal, so clear again once it has landed.
    gray_in = 4'b0000;
    repeat (4) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (multi_bit_err !== 1'b0 || bin_out !== 4'd0) begin
      errors++; $display("FAIL errclr_setup err=%0b bin=%0d exp 0/0", multi_bit_err, bin_out);
    end
    gray_in = 4'b0011;
    step();
    step();
    checks++; if (multi_bit_err !== 1'b0) begin errors++; $display("FAIL errclr_pre got=%0b exp=0", multi_bit_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (multi_bit_err !== 1'b1) begin errors++; $display("FAIL errclr_set_wins got=%0b exp=1", multi_bit_err); end
    checks++; if (bin_out !== 4'd2 || ptr_delta !== 4'd2) begin
      errors++; $display("FAIL errclr_bin bin=%0d delta=%0d exp 2/2", bin_out, ptr_delta);
    end
    step();
  endtask

  task automatic test_mid_reset();
    gray_in = bin2gray(4'd9);
    repeat (4) step();
    checks++; if (bin_out !== 4'd9) begin errors++; $display("FAIL midrst_setup got=%0d exp=9", bin_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (bin_out !== 4'd0 || gray_sync !== 4'd0) begin
      errors++; $display("FAIL midrst_async bin=%0d gray=%0d exp 0/0", bin_out, gray_sync);
    end
    checks++; if (ptr_update !== 1'b0 || ptr_delta !== 4'd0 || multi_bit_err !== 1'b0) begin
      errors++; $display("FAIL midrst_async_flags upd=%0b delta=%0d err=%0b exp 0/0/0", ptr_update, ptr_delta, multi_bit_err);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++; if (bin_out !== 4'd0) begin errors++; $display("FAIL midrst_early got=%0d exp=0", bin_out); end
    step();
    checks++; if (bin_out !== 4'd9) begin errors++; $display("FAIL midrst_bin got=%0d exp=9", bin_out); end
    checks++; if (ptr_update !== 1'b1 || ptr_delta !== 4'd9) begin
      errors++; $display("FAIL midrst_update upd=%0b delta=%0d exp 1/9", ptr_update, ptr_delta);
    end
    checks++; if (multi_bit_err !== 1'b1) begin errors++; $display("FAIL midrst_err got=%0b exp=1", multi_bit_err); end
  endtask

  task automatic test_stable();
    int bad_upd;
    int bad_delta;
    int bad_bin;
    bad_upd   = 0;
    bad_delta = 0;
    bad_bin   = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (ptr_update !== 1'b0) bad_upd++;
      if (ptr_delta !== 4'd0) bad_delta++;
      if (bin_out !== 4'd9) bad_bin++;
    end
    checks++; if (bad_upd != 0) begin errors++; $display("FAIL stable_update bad_cycles=%0d exp=0", bad_upd); end
    checks++; if (bad_delta != 0) begin errors++; $display("FAIL stable_delta bad_cycles=%0d exp=0", bad_delta); end
    checks++; if (bad_bin != 0) begin errors++; $display("FAIL stable_bin bad_cycles=%0d exp=0", bad_bin); end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    gray_in = 4'd0;
    err_clr = 1'b0;
    test_reset();
    test_count();
    test_multi_step();
    test_err_clr();
    test_mid_reset();
    test_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
